// File: rtl/mempool_bank_arbiter_pkg.sv
// Shared types and sizes for the TCDM bank arbiter and its round-robin picker.
package mempool_bank_arbiter_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NumCoresPerTile  = 4;
  localparam int unsigned NumBankInputs    = NumCoresPerTile + 1;
  localparam int unsigned TCDMAddrMemWidth = 8;
  localparam int unsigned DataWidth        = 32;
  localparam int unsigned BeWidth          = DataWidth / 8;
  localparam int unsigned MetaIdWidth      = 4;
  localparam int unsigned CoreIdWidth      = 3;
  localparam int unsigned AmoWidth         = 4;
  localparam int unsigned BankIdxWidth     = idx_width(NumBankInputs);

  typedef logic [TCDMAddrMemWidth-1:0] bank_addr_t;
  typedef logic [BeWidth-1:0]          strb_t;

  typedef struct packed {
    logic [MetaIdWidth-1:0] meta_id;
    logic [CoreIdWidth-1:0] core_id;
    logic [AmoWidth-1:0]    amo;
    logic [DataWidth-1:0]   data;
  } tcdm_payload_t;

  typedef struct packed {
    logic [BankIdxWidth-1:0] idx;
    tcdm_payload_t           payload;
  } bank_resp_entry_t;

endpackage

// File: rtl/mempool_rr_arbiter.sv
// Rotating-priority pick: first eligible index starting at rr_i, wrapping modulo NumInp.
module mempool_rr_arbiter
  import mempool_bank_arbiter_pkg::*;
#(
  parameter int unsigned NumInp = NumBankInputs,
  parameter int unsigned IdxW   = idx_width(NumInp)
) (
  input  logic [NumInp-1:0] eligible_i,
  input  logic [IdxW-1:0]   rr_i,
  output logic [NumInp-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      cand     = (32'(rr_i) + k) % NumInp;
      cand_idx = IdxW'(cand);
      if (!gnt_valid_o && eligible_i[cand_idx]) begin
        gnt_valid_o     = 1'b1;
        gnt_idx_o       = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mempool_bank_arbiter.sv
// Shares one 1-cycle-latency SRAM bank among NumInp requesters; read data returns
// through a small in-order FIFO, with read grants throttled by FIFO credits.
module mempool_bank_arbiter
  import mempool_bank_arbiter_pkg::*;
#(
  parameter int unsigned NumInp    = NumBankInputs,
  parameter int unsigned RespDepth = 2,
  parameter int unsigned AddrW     = TCDMAddrMemWidth,
  parameter int unsigned IdxW      = idx_width(NumInp)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic          [NumInp-1:0]            req_valid_i,
  output logic          [NumInp-1:0]            req_ready_o,
  input  logic          [NumInp-1:0][AddrW-1:0] req_addr_i,
  input  logic          [NumInp-1:0]            req_wen_i,
  input  logic          [NumInp-1:0][BeWidth-1:0] req_be_i,
  input  tcdm_payload_t [NumInp-1:0]            req_wdata_i,
  output logic          [NumInp-1:0]            resp_valid_o,
  input  logic          [NumInp-1:0]            resp_ready_i,
  output tcdm_payload_t                         resp_rdata_o,
  output logic                                  bank_req_o,
  output logic                                  bank_we_o,
  output logic          [AddrW-1:0]             bank_addr_o,
  output logic          [DataWidth-1:0]         bank_wdata_o,
  output logic          [BeWidth-1:0]           bank_be_o,
  input  logic          [DataWidth-1:0]         bank_rdata_i
);

  localparam int unsigned PtrW = idx_width(RespDepth);
  localparam int unsigned CntW = $clog2(RespDepth + 1);
  localparam int unsigned OccW = CntW + 1;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [IdxW-1:0]  rr_q, rr_d;
  logic             rd_inflight_q, rd_inflight_d;
  bank_resp_entry_t meta_q, meta_d;
  bank_resp_entry_t [RespDepth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  fifo_count_q, fifo_count_d;

  logic [NumInp-1:0] eligible;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_valid;
  logic              credit_ok, push, pop;
  bank_resp_entry_t  head, push_entry;

  // Credit counts the in-flight read too, and ignores a same-cycle pop.
  always_comb begin
    credit_ok = (OccW'(fifo_count_q) + OccW'(rd_inflight_q)) < OccW'(RespDepth);
    for (int unsigned i = 0; i < NumInp; i++) begin
      eligible[i] = !rst_i && req_valid_i[i] && (req_wen_i[i] || credit_ok);
    end
  end

  mempool_rr_arbiter #(
    .NumInp (NumInp),
    .IdxW   (IdxW)
  ) i_rr_arbiter (
    .eligible_i  (eligible),
    .rr_i        (rr_q),
    .gnt_o       (req_ready_o),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    bank_req_o   = gnt_valid;
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    if (gnt_valid) begin
      bank_we_o    = req_wen_i[gnt_idx];
      bank_addr_o  = req_addr_i[gnt_idx];
      bank_wdata_o = req_wdata_i[gnt_idx].data;
      bank_be_o    = req_be_i[gnt_idx];
    end
  end

  // Arbitration pointer and read metadata held for the cycle the SRAM answers.
  always_comb begin
    rr_d          = rr_q;
    rd_inflight_d = 1'b0;
    meta_d        = meta_q;
    if (gnt_valid) begin
      rr_d = (gnt_idx == IdxW'(NumInp - 1)) ? '0 : gnt_idx + IdxW'(1);
      if (!req_wen_i[gnt_idx]) begin
        rd_inflight_d        = 1'b1;
        meta_d.idx           = BankIdxWidth'(gnt_idx);
        meta_d.payload       = req_wdata_i[gnt_idx];
        meta_d.payload.data  = '0;
      end
    end
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    resp_rdata_o = head.payload;
    resp_valid_o = '0;
    pop          = 1'b0;
    if (!rst_i && fifo_count_q != '0) begin
      resp_valid_o[head.idx] = 1'b1;
      pop                    = resp_ready_i[head.idx];
    end
  end

  always_comb begin
    push_entry              = meta_q;
    push_entry.payload.data = bank_rdata_i;
    push                    = rd_inflight_q;
    mem_d                   = mem_q;
    wr_ptr_d                = wr_ptr_q;
    rd_ptr_d                = rd_ptr_q;
    fifo_count_d            = fifo_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CntW'(1);
    end else if (pop && !push) begin
      fifo_count_d = fifo_count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q          <= '0;
      rd_inflight_q <= 1'b0;
      meta_q        <= '0;
      mem_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
    end else begin
      rr_q          <= rr_d;
      rd_inflight_q <= rd_inflight_d;
      meta_q        <= meta_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
    end
  end

`ifndef SYNTHESIS
  push_when_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_count_q == CntW'(RespDepth)));

  for (genvar i = 0; i < NumInp; i++) begin : g_req_hold
    req_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[i] && !req_ready_o[i]) |=>
        (req_valid_i[i] && $stable(req_wdata_i[i]) && $stable(req_addr_i[i])
         && $stable(req_wen_i[i])));
  end
`endif

endmodule

// File: tb/tb_mempool_bank_arbiter.sv
// Scoreboarded bench for mempool_bank_arbiter with a 1-cycle-latency SRAM model.
module tb_mempool_bank_arbiter;
  import mempool_bank_arbiter_pkg::*;

  localparam int unsigned N = NumBankInputs;

  logic                              clk_i;
  logic                              rst_i;
  logic          [N-1:0]             req_valid;
  logic          [N-1:0]             req_ready_o;
  logic          [N-1:0][7:0]        req_addr;
  logic          [N-1:0]             req_wen;
  logic          [N-1:0][BeWidth-1:0] req_be;
  tcdm_payload_t [N-1:0]             req_wdata;
  logic          [N-1:0]             resp_valid_o;
  logic          [N-1:0]             resp_ready;
  tcdm_payload_t                     resp_rdata_o;
  logic                              bank_req_o, bank_we_o;
  logic          [7:0]               bank_addr_o;
  logic          [DataWidth-1:0]     bank_wdata_o;
  logic          [BeWidth-1:0]       bank_be_o;
  logic          [DataWidth-1:0]     bank_rdata_i;

  mempool_bank_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr),
    .req_wen_i    (req_wen),
    .req_be_i     (req_be),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata_o),
    .bank_req_o   (bank_req_o),
    .bank_we_o    (bank_we_o),
    .bank_addr_o  (bank_addr_o),
    .bank_wdata_o (bank_wdata_o),
    .bank_be_o    (bank_be_o),
    .bank_rdata_i (bank_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // SRAM model: byte-enabled writes, read data valid one cycle after the enable.
  logic [DataWidth-1:0] mem [256];
  always @(posedge clk_i) begin
    if (bank_req_o && bank_we_o) begin
      for (int b = 0; b < int'(BeWidth); b++) begin
        if (bank_be_o[b]) mem[bank_addr_o][8*b +: 8] = bank_wdata_o[8*b +: 8];
      end
    end
    if (bank_req_o && !bank_we_o) bank_rdata_i <= mem[bank_addr_o];
    else                          bank_rdata_i <= $urandom;
  end

  int checks = 0;
  int errors = 0;
  bank_resp_entry_t sb_q[$];

  logic [N-1:0]  ready_s, resp_valid_s;
  logic          bank_req_s, bank_we_s;
  logic [7:0]    bank_addr_s;
  tcdm_payload_t rdata_s;

  // One clock: sample at negedge, feed the scoreboard, return just after posedge.
  task automatic tick();
    bank_resp_entry_t exp_e;
    logic [N-1:0] oh;
    @(negedge clk_i);
    ready_s      = req_ready_o;
    resp_valid_s = resp_valid_o;
    bank_req_s   = bank_req_o;
    bank_we_s    = bank_we_o;
    bank_addr_s  = bank_addr_o;
    rdata_s      = resp_rdata_o;
    checks++;
    if ($countones(ready_s) > 1 || bank_req_s !== (ready_s != '0)) begin
      errors++;
      $display("FAIL grant_onehot: ready=%b bank_req=%b, required one-hot ready matching bank_req",
               ready_s, bank_req_s);
    end
    if (!rst_i) begin
      for (int i = 0; i < int'(N); i++) begin
        if (ready_s[i] && !req_wen[i]) begin
          exp_e.idx          = BankIdxWidth'(i);
          exp_e.payload      = req_wdata[i];
          exp_e.payload.data = mem[req_addr[i]];
          sb_q.push_back(exp_e);
        end
      end
      if ((resp_valid_s & resp_ready) != '0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: resp_valid=%b, required no response", resp_valid_s);
        end else begin
          exp_e = sb_q.pop_front();
          oh = '0;
          oh[exp_e.idx] = 1'b1;
          if (resp_valid_s !== oh || rdata_s !== exp_e.payload) begin
            errors++;
            $display("FAIL resp_data: valid=%b rdata=%h, required valid=%b rdata=%h",
                     resp_valid_s, rdata_s, oh, exp_e.payload);
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  // Drop each request only once granted, until nothing is pending.
  task automatic drain();
    for (int c = 0; c < 40 && req_valid != '0; c++) begin
      tick();
      req_valid &= ~ready_s;
    end
    checks++;
    if (req_valid != '0) begin
      errors++;
      $display("FAIL drain: pending=%b, required all granted", req_valid);
      req_valid = '0;
    end
  endtask

  task automatic wait_idle();
    resp_ready = '1;
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) tick();
    tick();
    checks++;
    if (sb_q.size() != 0 || resp_valid_s !== '0) begin
      errors++;
      $display("FAIL idle: outstanding=%0d resp_valid=%b, required 0 and 0", sb_q.size(), resp_valid_s);
    end
  endtask

  task automatic test_reset();
    rst_i      = 1'b1;
    resp_ready = '1;
    for (int i = 0; i < int'(N); i++) begin
      req_addr[i]  = 8'h10 + 8'(i);
      req_be[i]    = '1;
      req_wdata[i] = '{meta_id: 4'(i), core_id: 3'(i), amo: 4'h0, data: 32'h1000_0000 + 32'(i)};
    end
    req_wen   = '1;
    req_valid = '1;
    tick();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ready_s !== '0) begin
        errors++; $display("FAIL reset_ready: got %b, required 00000", ready_s);
      end
      checks++;
      if (bank_req_s !== 1'b0) begin
        errors++; $display("FAIL reset_bank_req: got %b, required 0", bank_req_s);
      end
      checks++;
      if (resp_valid_s !== '0) begin
        errors++; $display("FAIL reset_resp_valid: got %b, required 00000", resp_valid_s);
      end
    end
    rst_i = 1'b0;
    tick();
    checks++;
    if (ready_s !== 5'b00001) begin
      errors++; $display("FAIL reset_first_grant: got %b, required 00001", ready_s);
    end
    req_valid &= ~ready_s;
    drain();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    req_wen   = '1;
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_g = '0;
      exp_g[k % N] = 1'b1;
      checks++;
      if (ready_s !== exp_g || bank_we_s !== 1'b1 || bank_addr_s !== 8'h10 + 8'(k % N)) begin
        errors++;
        $display("FAIL rr_order step %0d: ready=%b we=%b addr=%h, required ready=%b we=1 addr=%h",
                 k, ready_s, bank_we_s, bank_addr_s, exp_g, 8'h10 + 8'(k % N));
      end
    end
    drain();
  endtask

  task automatic test_read_return();
    req_wen[4]        = 1'b1;
    req_addr[4]       = 8'h2A;
    req_wdata[4].data = 32'hDEADBEEF;
    req_valid         = 5'b10000;
    tick();
    req_valid = '0;
    req_wen[3]   = 1'b0;
    req_addr[3]  = 8'h2A;
    req_wdata[3] = '{meta_id: 4'd5, core_id: 3'd3, amo: 4'hA, data: 32'h0BAD_F00D};
    req_valid    = 5'b01000;
    tick();
    checks++;
    if (ready_s !== 5'b01000 || bank_we_s !== 1'b0 || bank_addr_s !== 8'h2A) begin
      errors++;
      $display("FAIL read_grant: ready=%b we=%b addr=%h, required 01000 0 2a", ready_s, bank_we_s, bank_addr_s);
    end
    req_valid = '0;
    tick();
    checks++;
    if (resp_valid_s !== '0) begin
      errors++; $display("FAIL read_early: resp_valid=%b at t+1, required 00000", resp_valid_s);
    end
    tick();
    checks++;
    if (resp_valid_s !== 5'b01000 || rdata_s.data !== 32'hDEADBEEF || rdata_s.meta_id !== 4'd5
        || rdata_s.core_id !== 3'd3 || rdata_s.amo !== 4'hA) begin
      errors++;
      $display("FAIL read_return: valid=%b rdata=%h, required valid=01000 meta=5 core=3 amo=a data=deadbeef",
               resp_valid_s, rdata_s);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_seq [5];
    exp_seq = '{5'b00001, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
    resp_ready = '0;
    req_wen[0] = 1'b0;
    req_wen[1] = 1'b0;
    req_valid  = 5'b00011;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (ready_s !== exp_seq[k]) begin
        errors++; $display("FAIL credit_step %0d: ready=%b, required %b", k, ready_s, exp_seq[k]);
      end
    end
    req_wen[2]   = 1'b1;
    req_valid[2] = 1'b1;
    tick();
    checks++;
    if (ready_s !== 5'b00100 || bank_we_s !== 1'b1) begin
      errors++; $display("FAIL write_past_reads: ready=%b we=%b, required 00100 1", ready_s, bank_we_s);
    end
    req_valid[2] = 1'b0;
    tick();
    checks++;
    if (resp_valid_s !== 5'b00001 || ready_s !== '0) begin
      errors++; $display("FAIL resp_hold: valid=%b ready=%b, required 00001 00000", resp_valid_s, ready_s);
    end
    resp_ready = '1;
    tick();
    checks++;
    if (resp_valid_s !== 5'b00001 || ready_s !== '0) begin
      errors++; $display("FAIL pop_no_bypass: valid=%b ready=%b, required 00001 00000", resp_valid_s, ready_s);
    end
    tick();
    checks++;
    if (resp_valid_s !== 5'b00010 || ready_s !== 5'b00001) begin
      errors++; $display("FAIL reads_resume: valid=%b ready=%b, required 00010 00001", resp_valid_s, ready_s);
    end
    req_valid &= ~ready_s;
    drain();
    wait_idle();
  endtask

  task automatic test_reset_midflight();
    resp_ready  = '1;
    req_wen[2]  = 1'b0;
    req_addr[2] = 8'h2A;
    req_valid   = 5'b00100;
    tick();
    checks++;
    if (ready_s !== 5'b00100) begin
      errors++; $display("FAIL midflight_grant: ready=%b, required 00100", ready_s);
    end
    req_valid = '0;
    rst_i     = 1'b1;
    tick();
    sb_q.delete();
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (resp_valid_s !== '0) begin
        errors++; $display("FAIL midflight_resp: resp_valid=%b, required 00000", resp_valid_s);
      end
    end
    req_wen   = '1;
    req_valid = '1;
    tick();
    checks++;
    if (ready_s !== 5'b00001) begin
      errors++; $display("FAIL midflight_rr: ready=%b, required 00001", ready_s);
    end
    req_valid &= ~ready_s;
    drain();
  endtask

  task automatic test_wrap_skip();
    logic [N-1:0] exp_seq [3];
    exp_seq   = '{5'b10000, 5'b00010, 5'b10000};
    req_wen   = '1;
    req_valid = 5'b01000;
    tick();
    checks++;
    if (ready_s !== 5'b01000) begin
      errors++; $display("FAIL wrap_setup: ready=%b, required 01000", ready_s);
    end
    req_valid = 5'b10010;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ready_s !== exp_seq[k]) begin
        errors++; $display("FAIL wrap_step %0d: ready=%b, required %b", k, ready_s, exp_seq[k]);
      end
    end
    req_valid &= ~ready_s;
    drain();
    wait_idle();
  endtask

  initial begin
    rst_i        = 1'b1;
    req_valid    = '0;
    req_wen      = '0;
    req_addr     = '0;
    req_be       = '0;
    req_wdata    = '0;
    resp_ready   = '0;
    test_reset();
    test_round_robin();
    test_read_return();
    test_backpressure();
    test_reset_midflight();
    test_wrap_skip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
